reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised multi-port integer register file with an integrated busy-bit scoreboard, for the wider-issue NPC core. Supports NRD combinational read ports and NWR synchronous write ports, with optional same-cycle write-to-read bypass. Per-register busy bits are set on producer allocation and cleared on write-back, so decode can stall on RAW hazards without a separate scoreboard block.

Parameters:
XLEN, 64, data width in bits
NREG, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports (>=1)
NWR, 1, number of write ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see registered state only
AW, $clog2(NREG), address width (derived; not overridden)

Ports:
clock  in  1  single clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all registers and busy bits
rd_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rd_data  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
rd_busy  out  NRD  busy flag of the register addressed by port k
wen  in  NWR  write enable per write port
waddr  in  NWR*AW  write addresses
wdata  in  NWR*XLEN  write data
alloc_en  in  1  mark alloc_addr busy (producer issued)
alloc_addr  in  AW  register being allocated
flush  in  1  synchronous clear of all busy bits (pipeline flush); register contents kept
busy_vec  out  NREG  current registered busy bits, bit i = register i

Behaviour:
- Register 0 hardwired: reads return 0, busy always 0; writes and allocs to address 0 ignored.
- Reset (async, while high): all NREG registers = 0, all busy bits = 0, busy_vec = 0; rd_data = 0, rd_busy = 0 regardless of addresses; bypass suppressed; writes/allocs ignored. First update on first posedge after reset deasserts.
- Write: on posedge, for each port j with wen[j] and waddr[j]!=0, reg[waddr[j]] <= wdata[j]. Write latency 1 cycle to registered state.
- Write-write conflict (same address, multiple enabled ports): highest-indexed port wins, for both storage and bypass.
- Read: combinational, zero latency. BYPASS=0: rd_data = reg[rd_addr]. BYPASS=1: if any enabled write port targets rd_addr (!=0) this cycle, rd_data = that port's wdata (highest index wins); else reg[rd_addr].
- Busy update, per register i!=0, on posedge, priority highest first:
  1. flush -> busy[i] <= 0 (overrides alloc and write in same cycle)
  2. alloc_en && alloc_addr==i -> busy[i] <= 1 (new producer wins over a same-cycle write-back of the old one)
  3. any enabled write to i -> busy[i] <= 0
  4. else hold
- rd_busy[k]: BYPASS=0: busy[rd_addr[k]]. BYPASS=1: busy[rd_addr[k]] AND NOT (enabled write to rd_addr[k] this cycle); same-cycle alloc does not affect rd_busy (takes effect next cycle). Address 0 always 0.
- busy_vec reflects registered state only (no bypass).
- No out-of-range addresses possible (NREG power of two).
- Write with busy bit already clear is legal: data stored, busy stays 0.

Test Plan:
- Reset: drive wen=1, waddr=5, wdata=0xAA during reset -> after release rd_addr=5 reads 0, busy_vec=0; reset asserted mid-run clears stored 0x1234 at r7 immediately (same cycle, no clock edge).
- Write/read + x0: write r3=0xDEADBEEF_CAFEF00D, then r0=0xFFFF -> next cycle rd_addr=3 reads written value, rd_addr=0 reads 0 on both ports.
- Bypass: BYPASS=1, wen=1 waddr=9 wdata=0x55 with rd_addr=9 same cycle -> rd_data=0x55, rd_busy=0; BYPASS=0 same stimulus -> old value 0 returned.
- Scoreboard: alloc r4 -> busy_vec[4]=1 next cycle, rd_busy=1; write r4 -> busy cleared next cycle; alloc r4 and write r4 same cycle -> busy_vec[4]=1 and data updated.
- Multi-write: NWR=2, both ports write r6 with 0x11 (port0) and 0x22 (port1) -> r6=0x22, bypass read 0x22.
- Flush: set busy on r1,r2,r31; assert flush with alloc r5 same cycle -> busy_vec=0 next cycle, registers unchanged.

Source files
------------

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Multi-port integer register file with an integrated busy-bit scoreboard.
// Register 0 is hardwired to zero and is never marked busy.
//
// Ports
//   clock       single clock, all state updates on posedge
//   reset       asynchronous active-high; clears registers and busy bits
//   rd_addr     NRD read addresses, port k at [k*AW +: AW]
//   rd_data     NRD read data (combinational), port k at [k*XLEN +: XLEN]
//   rd_busy     busy flag of the register addressed by each read port
//   wen         per-write-port enable
//   waddr       NWR write addresses, port j at [j*AW +: AW]
//   wdata       NWR write data, port j at [j*XLEN +: XLEN]
//   alloc_en    mark alloc_addr busy (producer issued)
//   alloc_addr  register being allocated
//   flush       synchronous clear of all busy bits; register contents kept
//   busy_vec    registered busy bits, bit i = register i
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Register storage. Ports are visited in ascending order, so when several
    // ports target the same address the last scheduled update (highest port)
    // is the one that sticks.
    // NOTE: the array sits on the async reset because reset must make every
    // register read back as zero immediately; a memory without reset would
    // map to plain RAM but could not meet that.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && waddr[j*AW +: AW] != '0) begin
                    regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Busy next-state: later statements override earlier ones, which gives
    // the priority flush > alloc > write-back > hold.
    // NOTE: the whole vector is given a value before any conditional update,
    // so no path leaves a bit unassigned and no latch is inferred.
    always_comb begin
        busy_next = busy;
        for (int j = 0; j < NWR; j++) begin
            if (wen[j]) begin
                busy_next[waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_next[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_vec = busy;

    // Combinational read ports. With bypass, a same-cycle write to the read
    // address forwards its data (highest port wins) and hides the busy bit,
    // since the producer's result is available right now. A same-cycle
    // allocation is deliberately not looked at here.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
            rd_busy[k]              = busy[rd_addr[k*AW +: AW]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wen[j] && waddr[j*AW +: AW] == rd_addr[k*AW +: AW]) begin
                        rd_data[k*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
                        rd_busy[k]              = 1'b0;
                    end
                end
            end
            // x0 reads zero and is never busy; reset also blocks forwarding.
            if (reset || rd_addr[k*AW +: AW] == '0) begin
                rd_data[k*XLEN +: XLEN] = '0;
                rd_busy[k]              = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Self-checking bench for reg_file_sb. Two instances share all inputs: one
// with bypass, one without, both with two read and two write ports. A
// behavioural model (plain arrays updated by the scoreboard rules) predicts
// every read port, busy flag and the busy vector each cycle.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clock;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                flush;

    logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NRD-1:0]      rd_busy_b, rd_busy_n;
    logic [NREG-1:0]     busy_vec_b, busy_vec_n;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural state only.
    logic [XLEN-1:0] m_regs [NREG];
    logic            m_busy [NREG];

    reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_byp (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wen(wen), .waddr(waddr), .wdata(wdata),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
        .busy_vec(busy_vec_b)
    );

    reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nob (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
        .busy_vec(busy_vec_n)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] raddr(input int k);
        return rd_addr[k*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] waddr_of(input int j);
        return waddr[j*AW +: AW];
    endfunction

    // Expected read data: stored value, replaced by the highest-numbered
    // same-cycle write to that address when forwarding is on.
    function automatic logic [XLEN-1:0] exp_data(input int k, input bit byp);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        a = raddr(k);
        v = m_regs[a];
        if (byp) begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && waddr_of(j) == a) v = wdata[j*XLEN +: XLEN];
            end
        end
        if (reset || a == 0) v = '0;
        return v;
    endfunction

    function automatic logic exp_busy(input int k, input bit byp);
        logic [AW-1:0] a;
        logic          hit;
        a   = raddr(k);
        hit = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (wen[j] && waddr_of(j) == a) hit = 1'b1;
        end
        if (reset || a == 0) return 1'b0;
        if (byp && hit) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [NREG-1:0] exp_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply one clock edge to the model, straight from the scoreboard rules.
    task automatic model_step();
        logic wr_hit;
        if (reset) begin
            model_clear();
            return;
        end
        for (int i = 1; i < NREG; i++) begin
            wr_hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && waddr_of(j) == i) begin
                    m_regs[i] = wdata[j*XLEN +: XLEN];
                    wr_hit    = 1'b1;
                end
            end
            if (flush)                           m_busy[i] = 1'b0;
            else if (alloc_en && alloc_addr == i) m_busy[i] = 1'b1;
            else if (wr_hit)                     m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("%s.data_b%0d", tag, k), rd_data_b[k*XLEN +: XLEN], exp_data(k, 1'b1));
            check($sformatf("%s.data_n%0d", tag, k), rd_data_n[k*XLEN +: XLEN], exp_data(k, 1'b0));
            check($sformatf("%s.busy_b%0d", tag, k), 64'(rd_busy_b[k]), 64'(exp_busy(k, 1'b1)));
            check($sformatf("%s.busy_n%0d", tag, k), 64'(rd_busy_n[k]), 64'(exp_busy(k, 1'b0)));
        end
        check({tag, ".vec_b"}, 64'(busy_vec_b), 64'(exp_vec()));
        check({tag, ".vec_n"}, 64'(busy_vec_n), 64'(exp_vec()));
    endtask

    // Inputs are driven just after a negedge; check, clock, update model.
    task automatic tick(input string tag);
        #1;
        check_all(tag);
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic set_idle();
        wen        = '0;
        waddr      = '0;
        wdata      = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        flush      = 1'b0;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wen              = 2'b01;
        waddr[AW-1:0]    = a;
        wdata[XLEN-1:0]  = d;
    endtask

    task automatic alloc(input logic [AW-1:0] a);
        alloc_en   = 1'b1;
        alloc_addr = a;
    endtask

    initial begin
        model_clear();
        reset   = 1'b1;
        set_idle();
        rd_addr = {5'd5, 5'd5};
        wr0(5'd5, 64'hAA);
        alloc(5'd5);

        // Writes and allocs during reset must be ignored.
        tick("rst_hold0");
        tick("rst_hold1");
        reset = 1'b0;
        set_idle();
        #1;
        check("post_rst_r5", rd_data_n[63:0], 64'h0);
        check("post_rst_vec", 64'(busy_vec_b), 64'h0);
        tick("post_rst");

        // Write r3, then try to write r0.
        wr0(5'd3, 64'hDEADBEEF_CAFEF00D);
        tick("wr_r3");
        wr0(5'd0, 64'hFFFF);
        tick("wr_r0");
        set_idle();
        rd_addr = {5'd0, 5'd3};
        #1;
        check("rd_r3", rd_data_n[63:0], 64'hDEADBEEF_CAFEF00D);
        check("rd_r0_p1", rd_data_b[127:64], 64'h0);
        tick("rd_r3_r0");
        rd_addr = {5'd0, 5'd0};
        #1;
        check("rd_r0_p0", rd_data_b[63:0], 64'h0);
        tick("rd_r0_both");

        // Bypass: r9 busy, then written while being read.
        alloc(5'd9);
        tick("alloc_r9");
        set_idle();
        wr0(5'd9, 64'h55);
        rd_addr = {5'd0, 5'd9};
        #1;
        check("byp_data", rd_data_b[63:0], 64'h55);
        check("byp_busy", 64'(rd_busy_b[0]), 64'h0);
        check("nob_data", rd_data_n[63:0], 64'h0);
        check("nob_busy", 64'(rd_busy_n[0]), 64'h1);
        tick("byp_r9");

        // Scoreboard on r4.
        set_idle();
        alloc(5'd4);
        tick("alloc_r4");
        set_idle();
        rd_addr = {5'd4, 5'd4};
        #1;
        check("r4_busy_vec", 64'(busy_vec_b[4]), 64'h1);
        check("r4_rd_busy", 64'(rd_busy_n[1]), 64'h1);
        wr0(5'd4, 64'h44);
        tick("wb_r4");
        set_idle();
        #1;
        check("r4_cleared", 64'(busy_vec_n[4]), 64'h0);
        alloc(5'd4);
        wr0(5'd4, 64'h4444);
        tick("alloc_wb_r4");
        set_idle();
        #1;
        check("r4_realloc", 64'(busy_vec_b[4]), 64'h1);
        check("r4_data", rd_data_n[63:0], 64'h4444);
        tick("r4_after");

        // Two ports writing r6: port 1 wins.
        wen     = 2'b11;
        waddr   = {5'd6, 5'd6};
        wdata   = {64'h22, 64'h11};
        rd_addr = {5'd6, 5'd6};
        #1;
        check("ww_byp", rd_data_b[63:0], 64'h22);
        check("ww_nob_old", rd_data_n[63:0], 64'h0);
        tick("ww_r6");
        set_idle();
        #1;
        check("ww_stored", rd_data_n[127:64], 64'h22);
        tick("ww_read");

        // Flush beats a same-cycle alloc.
        alloc(5'd1);
        tick("alloc_r1");
        alloc(5'd2);
        tick("alloc_r2");
        alloc(5'd31);
        tick("alloc_r31");
        set_idle();
        #1;
        check("pre_flush", 64'(busy_vec_b & 32'h8000_0006), 64'h8000_0006);
        flush = 1'b1;
        alloc(5'd5);
        tick("flush");
        set_idle();
        rd_addr = {5'd6, 5'd3};
        #1;
        check("flush_vec_b", 64'(busy_vec_b), 64'h0);
        check("flush_vec_n", 64'(busy_vec_n), 64'h0);
        check("flush_keep_r3", rd_data_n[63:0], 64'hDEADBEEF_CAFEF00D);
        check("flush_keep_r6", rd_data_n[127:64], 64'h22);
        tick("post_flush");

        // Asynchronous reset mid-run clears r7 with no clock edge.
        wr0(5'd7, 64'h1234);
        tick("wr_r7");
        set_idle();
        rd_addr = {5'd7, 5'd7};
        #1;
        check("r7_stored", rd_data_n[63:0], 64'h1234);
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        check("r7_async_clr_n", rd_data_n[63:0], 64'h0);
        check("r7_async_clr_b", rd_data_b[127:64], 64'h0);
        @(negedge clock);
        tick("rst_mid");
        reset = 1'b0;

        // Randomised traffic; addresses biased low so hits are frequent.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NRD; k++) begin
                rd_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            end
            wen = NWR'($urandom_range(0, 3));
            for (int j = 0; j < NWR; j++) begin
                waddr[j*AW +: AW]     = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
                wdata[j*XLEN +: XLEN] = {$urandom, $urandom};
            end
            alloc_en   = ($urandom_range(0, 2) == 0);
            alloc_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 15) == 0);
            tick($sformatf("rnd%0d", c));
        end

        set_idle();
        tick("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
